// File: rtl/key_search_pkg.sv
// Shared types for the RC4 key-space dispatcher.
// Top-level sweep states and per-core lane states.
package key_search_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        STOP,
        DONE
    } top_state_t;

    typedef enum logic [1:0] {
        LANE_IDLE,
        LANE_RUN,
        LANE_DRAIN
    } lane_state_t;

endpackage

// File: rtl/dispatch_lane.sv
// One dispatcher lane: owns a decoder core's key counter,
// drives its start/key, and turns its verdict into a hit pulse.
module dispatch_lane
    import key_search_pkg::*;
#(
    parameter int          KEY_BITS  = 24,
    parameter int          NUM_CORES = 4,
    parameter int          LANE      = 0,
    parameter int unsigned KEY_MAX   = 32'h3F_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic                issue_en_i,
    input  logic                core_finish_i,
    input  logic                core_key_valid_i,
    output logic                core_start_o,
    output logic [KEY_BITS-1:0] core_key_o,
    output logic                hit_o,
    output logic                idle_o,
    output logic                spent_o
);

    localparam int CW = KEY_BITS + 1;

    // One spare bit so stepping past KEY_MAX never wraps.
    localparam logic [CW-1:0] LIMIT   = CW'(KEY_MAX);
    localparam logic [CW-1:0] FIRST   = CW'(LANE);
    localparam logic [CW-1:0] STEP    = CW'(NUM_CORES);

    lane_state_t         state_q;
    lane_state_t         state_d;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [KEY_BITS-1:0] key_q;
    logic [KEY_BITS-1:0] key_d;
    logic                start_q;
    logic                start_d;
    logic                can_issue;

    assign can_issue = issue_en_i && (cnt_q <= LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LANE_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LANE_IDLE: begin
                if (can_issue) begin
                    state_d = LANE_RUN;
                end
            end
            LANE_RUN: begin
                if (core_finish_i) begin
                    state_d = LANE_DRAIN;
                end
            end
            LANE_DRAIN: begin
                if (!core_finish_i) begin
                    state_d = LANE_IDLE;
                end
            end
            default: begin
                state_d = LANE_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        key_d   = key_q;
        start_d = start_q;
        hit_o   = 1'b0;
        unique case (state_q)
            LANE_IDLE: begin
                if (can_issue) begin
                    key_d   = cnt_q[KEY_BITS-1:0];
                    start_d = 1'b1;
                end
            end
            LANE_RUN: begin
                if (core_finish_i) begin
                    hit_o   = core_key_valid_i;
                    start_d = 1'b0;
                    cnt_d   = cnt_q + STEP;
                end
            end
            default: begin
                start_d = 1'b0;
            end
        endcase
        if (load_i) begin
            cnt_d = FIRST;
        end
    end

    assign core_start_o = start_q;
    assign core_key_o   = key_q;
    assign idle_o       = (state_q == LANE_IDLE);
    assign spent_o      = (cnt_q > LIMIT);

endmodule

// File: rtl/key_search_dispatcher.sv
// Sweeps the RC4 key space across NUM_CORES decoder cores and
// reports the first valid key, or exhaustion, to the UI.
module key_search_dispatcher
    import key_search_pkg::*;
#(
    parameter int          NUM_CORES = 4,
    parameter int          KEY_BITS  = 24,
    parameter int unsigned KEY_MAX   = 32'h3F_FFFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          search_start,
    input  logic [NUM_CORES-1:0]          core_finish,
    input  logic [NUM_CORES-1:0]          core_key_valid,
    output logic [NUM_CORES-1:0]          core_start,
    output logic [NUM_CORES*KEY_BITS-1:0] core_key,
    output logic                          busy,
    output logic                          done,
    output logic                          found,
    output logic [KEY_BITS-1:0]           found_key
);

    top_state_t          state_q;
    top_state_t          state_d;
    logic                found_q;
    logic                found_d;
    logic [KEY_BITS-1:0] found_key_q;
    logic [KEY_BITS-1:0] found_key_d;

    logic [NUM_CORES-1:0] hit;
    logic [NUM_CORES-1:0] idle;
    logic [NUM_CORES-1:0] spent;
    logic [KEY_BITS-1:0]  lane_key [NUM_CORES];
    logic [KEY_BITS-1:0]  win_key;

    logic any_hit;
    logic all_idle;
    logic exhausted;
    logic load;
    logic issue_en;

    assign any_hit   = |hit;
    assign all_idle  = &idle;
    assign exhausted = all_idle && (&spent);
    assign load      = search_start
                    && ((state_q == IDLE) || (state_q == DONE));

    // Gating on any_hit keeps idle lanes from issuing in the stop cycle.
    assign issue_en  = (state_q == SEARCH) && !any_hit;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_lane
        dispatch_lane #(
            .KEY_BITS  (KEY_BITS),
            .NUM_CORES (NUM_CORES),
            .LANE      (g),
            .KEY_MAX   (KEY_MAX)
        ) u_lane (
            .clk              (clk),
            .reset            (reset),
            .load_i           (load),
            .issue_en_i       (issue_en),
            .core_finish_i    (core_finish[g]),
            .core_key_valid_i (core_key_valid[g]),
            .core_start_o     (core_start[g]),
            .core_key_o       (lane_key[g]),
            .hit_o            (hit[g]),
            .idle_o           (idle[g]),
            .spent_o          (spent[g])
        );

        assign core_key[g*KEY_BITS +: KEY_BITS] = lane_key[g];
    end

    // Lowest-index hitting lane wins.
    always_comb begin
        win_key = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_key = lane_key[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            found_q     <= 1'b0;
            found_key_q <= '0;
        end else begin
            state_q     <= state_d;
            found_q     <= found_d;
            found_key_q <= found_key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (search_start) begin
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (any_hit || exhausted) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (all_idle) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (search_start) begin
                    state_d = SEARCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        found_d     = found_q;
        found_key_d = found_key_q;
        if (load) begin
            found_d     = 1'b0;
            found_key_d = '0;
        end else if ((state_q == SEARCH) && any_hit) begin
            found_d     = 1'b1;
            found_key_d = win_key;
        end
    end

    assign busy      = (state_q == SEARCH) || (state_q == STOP);
    assign done      = (state_q == DONE);
    assign found     = found_q;
    assign found_key = found_key_q;

endmodule

// File: tb/tb_key_search_dispatcher.sv
// Randomized bench for key_search_dispatcher with a behavioural
// core model and a batch-level reference for the expected verdict.
module tb_key_search_dispatcher;

    localparam int NC = 4;
    localparam int KB = 24;

    logic clk = 1'b0;
    logic reset;

    logic            ss       [2];
    logic [NC-1:0]   cf       [2];
    logic [NC-1:0]   kv       [2];
    logic [NC-1:0]   cs       [2];
    logic [NC*KB-1:0] ck      [2];
    logic            busy_s   [2];
    logic            done_s   [2];
    logic            found_s  [2];
    logic [KB-1:0]   fk       [2];

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0]   vmask      [2];
    int            extra_hold [2][NC];
    int            issued     [2][16];
    int            bad        [2];
    int            viol       [2];
    int            cnt        [2][NC];
    int            hold       [2][NC];
    bit            dropped    [2][NC];
    logic [KB-1:0] cur        [2][NC];
    int            held_cycles;

    logic          m_st;
    logic [KB-1:0] m_k;
    int            m_kmax;

    always #5 clk = ~clk;

    key_search_dispatcher #(
        .NUM_CORES (NC),
        .KEY_BITS  (KB),
        .KEY_MAX   (15)
    ) u_dut0 (
        .clk            (clk),
        .reset          (reset),
        .search_start   (ss[0]),
        .core_finish    (cf[0]),
        .core_key_valid (kv[0]),
        .core_start     (cs[0]),
        .core_key       (ck[0]),
        .busy           (busy_s[0]),
        .done           (done_s[0]),
        .found          (found_s[0]),
        .found_key      (fk[0])
    );

    key_search_dispatcher #(
        .NUM_CORES (NC),
        .KEY_BITS  (KB),
        .KEY_MAX   (2)
    ) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .search_start   (ss[1]),
        .core_finish    (cf[1]),
        .core_key_valid (kv[1]),
        .core_start     (cs[1]),
        .core_key       (ck[1]),
        .busy           (busy_s[1]),
        .done           (done_s[1]),
        .found          (found_s[1]),
        .found_key      (fk[1])
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decoder core: finishes 3 cycles after start, holds finish
    // until start drops (plus optional extra hold cycles).
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NC; i++) begin
                m_st   = cs[d][i];
                m_k    = ck[d][i*KB +: KB];
                m_kmax = (d == 0) ? 15 : 2;
                if (reset) begin
                    cf[d][i]      = 1'b0;
                    kv[d][i]      = 1'b0;
                    cnt[d][i]     = 0;
                    hold[d][i]    = 0;
                    dropped[d][i] = 1'b0;
                end else if (!cf[d][i]) begin
                    if (m_st) begin
                        if (cnt[d][i] == 0) begin
                            cur[d][i] = m_k;
                            if (m_k > KB'(m_kmax)) bad[d]++;
                            else issued[d][m_k[3:0]]++;
                        end else if (m_k != cur[d][i]) begin
                            viol[d]++;
                        end
                        cnt[d][i]++;
                        if (cnt[d][i] == 3) begin
                            cf[d][i]      = 1'b1;
                            kv[d][i]      = (m_k <= KB'(m_kmax))
                                          && vmask[d][m_k[3:0]];
                            hold[d][i]    = extra_hold[d][i];
                            dropped[d][i] = 1'b0;
                        end
                    end
                end else begin
                    if (m_st) begin
                        if (dropped[d][i]) viol[d]++;
                    end else begin
                        dropped[d][i] = 1'b1;
                        if (hold[d][i] > 0) begin
                            hold[d][i]--;
                            if (d == 0 && i == 0) held_cycles++;
                        end else begin
                            cf[d][i]  = 1'b0;
                            kv[d][i]  = 1'b0;
                            cnt[d][i] = 0;
                        end
                    end
                end
            end
        end
    end

    // Lockstep cores sweep keys in batches of NC; the first batch
    // holding a valid key ends the sweep, lowest key in it wins.
    function automatic void ref_model(input int kmax,
                                      input logic [15:0] mask,
                                      output logic f,
                                      output logic [KB-1:0] fke,
                                      output logic [15:0] im);
        f   = 1'b0;
        fke = '0;
        im  = '0;
        for (int b = 0; NC * b <= kmax && !f; b++) begin
            for (int k = NC * b; k < NC * (b + 1) && k <= kmax; k++) begin
                im[k] = 1'b1;
                if (mask[k] && !f) begin
                    f   = 1'b1;
                    fke = KB'(k);
                end
            end
        end
    endfunction

    task automatic run_search(input int d,
                              input logic [15:0] mask,
                              input int hold0,
                              input string tag);
        logic          ef;
        logic [KB-1:0] efk;
        logic [15:0]   eim;
        logic [15:0]   im;
        int            dup;
        int            kmax;
        kmax = (d == 0) ? 15 : 2;
        @(negedge clk);
        vmask[d]         = mask;
        extra_hold[d][0] = hold0;
        bad[d]           = 0;
        viol[d]          = 0;
        for (int k = 0; k < 16; k++) issued[d][k] = 0;
        ss[d] = 1'b1;
        @(negedge clk);
        ss[d] = 1'b0;
        @(negedge clk);
        if (d == 0) begin
            chk({tag, "_lat"}, 64'(cs[0]), 64'hF);
            chk({tag, "_k0"}, 64'(ck[0][0 +: KB]), 64'd0);
            chk({tag, "_k3"}, 64'(ck[0][3*KB +: KB]), 64'd3);
        end else begin
            chk({tag, "_lat"}, 64'(cs[1]), 64'h7);
        end
        for (int c = 0; c < 3000 && !done_s[d]; c++) @(negedge clk);
        chk({tag, "_done"}, 64'(done_s[d]), 64'd1);
        ref_model(kmax, mask, ef, efk, eim);
        im  = '0;
        dup = 0;
        for (int k = 0; k < 16; k++) begin
            if (issued[d][k] > 0) im[k] = 1'b1;
            if (issued[d][k] > 1) dup++;
        end
        chk({tag, "_found"}, 64'(found_s[d]), 64'(ef));
        chk({tag, "_fkey"}, 64'(fk[d]), 64'(efk));
        chk({tag, "_issued"}, 64'(im), 64'(eim));
        chk({tag, "_dup"}, 64'(dup), 64'd0);
        chk({tag, "_badkey"}, 64'(bad[d]), 64'd0);
        chk({tag, "_proto"}, 64'(viol[d]), 64'd0);
        chk({tag, "_start0"}, 64'(cs[d]), 64'd0);
        chk({tag, "_busy"}, 64'(busy_s[d]), 64'd0);
        extra_hold[d][0] = 0;
    endtask

    initial begin
        reset = 1'b1;
        ss[0] = 1'b0;
        ss[1] = 1'b0;
        held_cycles = 0;
        for (int d = 0; d < 2; d++) begin
            vmask[d] = '0;
            bad[d]   = 0;
            viol[d]  = 0;
            for (int i = 0; i < NC; i++) extra_hold[d][i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_start", 64'(cs[0]), 64'd0);
        chk("rst_key", 64'(|ck[0]), 64'd0);
        chk("rst_busy", 64'(busy_s[0]), 64'd0);
        chk("rst_done", 64'(done_s[0]), 64'd0);
        chk("rst_found", 64'(found_s[0]), 64'd0);
        chk("rst_fkey", 64'(fk[0]), 64'd0);
        #1 reset = 1'b0;

        run_search(0, 16'h0000, 0, "none");
        run_search(0, 16'h0040, 0, "key6");
        run_search(0, 16'h00A0, 0, "k5k7");
        held_cycles = 0;
        run_search(0, 16'h0000, 5, "hold");
        chk("hold_seen", 64'(held_cycles), 64'd20);
        run_search(1, 16'($urandom_range(0, 7)), 0, "km2");
        run_search(1, 16'h0000, 0, "km2none");

        // Mid-sweep reset, then a clean restart from key 0.
        @(negedge clk);
        vmask[0] = '0;
        ss[0] = 1'b1;
        @(negedge clk);
        ss[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy", 64'(busy_s[0]), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_start", 64'(cs[0]), 64'd0);
        chk("arst_key", 64'(|ck[0]), 64'd0);
        chk("arst_busy", 64'(busy_s[0]), 64'd0);
        chk("arst_found", 64'(found_s[0]), 64'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        run_search(0, 16'h0000, 0, "rerun");

        for (int r = 0; r < 6; r++) begin
            run_search(0, 16'($urandom) & 16'($urandom) & 16'($urandom),
                       0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
